// File: rtl/wb_uart_arbiter.sv
// rtl/wb_uart_arbiter.sv - two-master Wishbone B4 pipelined arbiter with per-grant watchdog
//
// Shares one Wishbone slave between two masters. Grants are round-robin and
// held for the whole cyc of the owner. A watchdog ends a grant when the slave
// has not acked for TIMEOUT consecutive granted cycles. The owner then sees a
// single-cycle err.
//
// Parameters:
//   TIMEOUT        granted cycles without ack before err (2..65535)
// Ports:
//   wb_clk_i       clock
//   wb_rst_i       asynchronous active-high reset
//   m0_wb_*        master 0 port: cyc/stb/we/dat in; dat/ack/stall/err out
//   m1_wb_*        master 1 port, same set as master 0
//   s_wb_*         slave port: cyc/stb/we/dat out; dat/ack/stall in
module wb_uart_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  output logic        m0_wb_err_o,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic        m1_wb_err_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ERR} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          own_cyc, oth_cyc;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // cyc of the current owner and of the waiting master; only meaningful in a grant state
  assign own_cyc = (state == GRANT1) ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign oth_cyc = (state == GRANT1) ? m0_wb_cyc_i : m1_wb_cyc_i;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          // tie: the master that was not granted last time wins
          state_nxt = last ? GRANT0 : GRANT1;
          last_nxt  = ~last;
        end else if (m0_wb_cyc_i) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_cyc) begin
          // release beats a coincident timeout
          tcnt_nxt = '0;
          if (oth_cyc) begin
            state_nxt = (state == GRANT0) ? GRANT1 : GRANT0;
            last_nxt  = (state == GRANT0);
          end else begin
            state_nxt = IDLE;
          end
        end else if (s_wb_ack_i) begin
          // an ack on the deadline cycle still counts as progress
          tcnt_nxt = '0;
        end else if (tcnt == CW'(TIMEOUT - 1)) begin
          state_nxt = ERR;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + CW'(1);
        end
      end
      ERR: begin
        // last keeps the timed-out master so the other one wins the next tie
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_dat_o    = '0;
    m0_wb_dat_o   = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m0_wb_err_o   = 1'b0;
    m1_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    m1_wb_err_o   = 1'b0;
    case (state)
      GRANT0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_dat_o    = m0_wb_dat_i;
        m0_wb_dat_o   = s_wb_dat_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      GRANT1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_dat_o    = m1_wb_dat_i;
        m1_wb_dat_o   = s_wb_dat_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      ERR: begin
        if (last) m1_wb_err_o = 1'b1;
        else      m0_wb_err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// tb/tb_wb_uart_arbiter.sv - self-checking bench for wb_uart_arbiter
module tb_wb_uart_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_stall, m0_err;
  logic [31:0] m0_dat_w, m0_dat_r;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_stall, m1_err;
  logic [31:0] m1_dat_w, m1_dat_r;
  logic        s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [31:0] s_dat_w, s_dat_r;

  int n_cmp = 0;
  int n_bad = 0;

  wb_uart_arbiter #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_dat_i(m0_dat_w),
    .m0_wb_dat_o(m0_dat_r), .m0_wb_ack_o(m0_ack), .m0_wb_stall_o(m0_stall), .m0_wb_err_o(m0_err),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_dat_i(m1_dat_w),
    .m1_wb_dat_o(m1_dat_r), .m1_wb_ack_o(m1_ack), .m1_wb_stall_o(m1_stall), .m1_wb_err_o(m1_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_dat_o(s_dat_w),
    .s_wb_dat_i(s_dat_r), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_dat_w = '0;
    s_ack = 0; s_stall = 0; s_dat_r = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_m(input int i, input logic v);
    if (i == 0) begin m0_cyc = v; m0_stb = v; end
    else        begin m1_cyc = v; m1_stb = v; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_dat_w = 32'h1234_5678;
    m1_cyc = 1; m1_stb = 1; s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_bad++; $display("FAIL reset_slave_ctl got %b want 000", {s_cyc, s_stb, s_we}); end
    n_cmp++; if (s_dat_w !== 32'h0) begin n_bad++; $display("FAIL reset_slave_dat got %h want 0", s_dat_w); end
    n_cmp++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    n_cmp++; if ({m0_stall, m1_stall} !== 2'b11) begin n_bad++; $display("FAIL reset_stall got %b want 11", {m0_stall, m1_stall}); end
    n_cmp++; if ({m0_dat_r, m1_dat_r} !== 64'h0) begin n_bad++; $display("FAIL reset_mdat got %h want 0", {m0_dat_r, m1_dat_r}); end
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_dat_w = 32'h41;
    #1;
    n_cmp++; if ({s_cyc, m0_stall, m1_stall} !== 3'b011) begin n_bad++; $display("FAIL wr_first got cyc/st0/st1=%b want 011", {s_cyc, m0_stall, m1_stall}); end
    @(negedge clk);
    s_ack = 1;
    #1;
    n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin n_bad++; $display("FAIL wr_ctl got %b want 111", {s_cyc, s_stb, s_we}); end
    n_cmp++; if (s_dat_w !== 32'h41) begin n_bad++; $display("FAIL wr_dat got %h want 41", s_dat_w); end
    n_cmp++; if ({m0_ack, m0_stall, m1_ack, m1_stall} !== 4'b1001) begin n_bad++; $display("FAIL wr_resp got %b want 1001", {m0_ack, m0_stall, m1_ack, m1_stall}); end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
    #1;
    n_cmp++; if ({s_cyc, m1_stall} !== 2'b01) begin n_bad++; $display("FAIL wr_release got %b want 01", {s_cyc, m1_stall}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({m0_stall, m1_stall, s_cyc} !== 3'b110) begin n_bad++; $display("FAIL wr_idle got %b want 110", {m0_stall, m1_stall, s_cyc}); end
  endtask

  // Round 0: tie -> m0, handover to m1. Round 1: tie -> m0 again (last was m1),
  // both drop together. Round 2: last is m0, so m1 wins the tie, then m0.
  task automatic test_round_robin();
    logic [31:0] dm [2];
    logic [1:0]  stl;
    int first, other;
    bit handover;
    dm[0] = 32'hA0A0_00A0;
    dm[1] = 32'hB1B1_00B1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      first = (r == 2) ? 1 : 0;
      other = 1 - first;
      handover = (r != 1);
      @(negedge clk);
      set_m(0, 1); set_m(1, 1); m0_dat_w = dm[0]; m1_dat_w = dm[1];
      #1;
      n_cmp++; if ({m0_stall, m1_stall, s_cyc} !== 3'b110) begin n_bad++; $display("FAIL rr_tie_wait r%0d got %b want 110", r, {m0_stall, m1_stall, s_cyc}); end
      @(negedge clk);
      #1;
      stl = {m1_stall, m0_stall};
      n_cmp++; if (s_dat_w !== dm[first] || stl[first] !== 1'b0 || stl[other] !== 1'b1) begin
        n_bad++; $display("FAIL rr_first r%0d got dat=%h stall=%b want dat=%h owner m%0d", r, s_dat_w, stl, dm[first], first);
      end
      @(negedge clk);
      set_m(first, 0);
      if (!handover) set_m(other, 0);
      @(negedge clk);
      #1;
      stl = {m1_stall, m0_stall};
      if (handover) begin
        n_cmp++; if (s_dat_w !== dm[other] || s_cyc !== 1'b1 || stl[other] !== 1'b0 || stl[first] !== 1'b1) begin
          n_bad++; $display("FAIL rr_handover r%0d got dat=%h cyc=%b stall=%b want dat=%h owner m%0d", r, s_dat_w, s_cyc, stl, dm[other], other);
        end
        set_m(other, 0);
      end else begin
        n_cmp++; if (s_cyc !== 1'b0 || stl !== 2'b11) begin n_bad++; $display("FAIL rr_idle r%0d got cyc=%b stall=%b want 0 11", r, s_cyc, stl); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pipelined_read();
    logic [4:0]  stb_v, stall_v, ack_v;
    logic [31:0] dat_v;
    int acks;
    stb_v = 5'b01111; stall_v = 5'b00010; ack_v = 5'b11010;
    acks = 0;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_dat_w = 32'h0;
    #1;
    n_cmp++; if ({m1_stall, s_stb} !== 2'b10) begin n_bad++; $display("FAIL rd_arb got %b want 10", {m1_stall, s_stb}); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m1_stb = stb_v[k]; s_stall = stall_v[k]; s_ack = ack_v[k];
      dat_v = (k == 1) ? 32'h11 : (k == 3) ? 32'h22 : (k == 4) ? 32'h33 : $urandom;
      s_dat_r = dat_v;
      #1;
      n_cmp++; if (m1_stall !== stall_v[k] || m1_ack !== ack_v[k] || m1_dat_r !== dat_v) begin
        n_bad++; $display("FAIL rd_beat%0d got st=%b ack=%b dat=%h want %b %b %h", k, m1_stall, m1_ack, m1_dat_r, stall_v[k], ack_v[k], dat_v);
      end
      n_cmp++; if (s_stb !== stb_v[k] || s_we !== 1'b0 || m0_dat_r !== 32'h0 || m0_stall !== 1'b1) begin
        n_bad++; $display("FAIL rd_side%0d got stb=%b we=%b m0dat=%h m0st=%b", k, s_stb, s_we, m0_dat_r, m0_stall);
      end
      if (m1_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL rd_ack_count got %0d want 3", acks); end
    @(negedge clk);
    clear_in();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int errs;
    errs = 0;
    @(negedge clk);
    set_m(0, 1); m0_dat_w = 32'hC0; m1_dat_w = 32'hC1;
    for (int g = 1; g <= TMO; g++) begin
      @(negedge clk);
      if (g == 2) set_m(1, 1);
      #1;
      if (m0_err === 1'b1) errs++;
      n_cmp++; if (s_cyc !== 1'b1 || m0_err !== 1'b0 || m1_stall !== 1'b1) begin
        n_bad++; $display("FAIL to_grant%0d got cyc=%b err=%b st1=%b want 1 0 1", g, s_cyc, m0_err, m1_stall);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({m0_err, m0_ack, s_cyc, m1_err, m0_stall} !== 5'b10001) begin
      n_bad++; $display("FAIL to_err got err/ack/cyc/err1/st0=%b want 10001", {m0_err, m0_ack, s_cyc, m1_err, m0_stall});
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({m0_err, s_cyc} !== 2'b00) begin n_bad++; $display("FAIL to_err_len got err/cyc=%b want 00", {m0_err, s_cyc}); end
    @(negedge clk);
    #1;
    n_cmp++; if (s_dat_w !== 32'hC1 || {m1_stall, m0_stall} !== 2'b01) begin
      n_bad++; $display("FAIL to_m1_first got dat=%h st1/st0=%b want C1 01", s_dat_w, {m1_stall, m0_stall});
    end
    @(negedge clk);
    set_m(1, 0);
    @(negedge clk);
    #1;
    n_cmp++; if (s_dat_w !== 32'hC0 || m0_stall !== 1'b0) begin n_bad++; $display("FAIL to_m0_after got dat=%h st0=%b want C0 0", s_dat_w, m0_stall); end
    set_m(0, 0);
    @(negedge clk);
  endtask

  task automatic test_ack_deadline();
    @(negedge clk);
    set_m(0, 1);
    for (int g = 1; g <= 2 * TMO; g++) begin
      @(negedge clk);
      s_ack = (g == TMO);
      if (g == 2 * TMO) set_m(0, 0);
      #1;
      n_cmp++; if (m0_err !== 1'b0 || m0_ack !== (g == TMO) || (g < 2 * TMO && s_cyc !== 1'b1)) begin
        n_bad++; $display("FAIL dl_cycle%0d got err=%b ack=%b cyc=%b", g, m0_err, m0_ack, s_cyc);
      end
    end
    @(negedge clk);
    s_ack = 0;
    #1;
    n_cmp++; if ({m0_err, s_cyc, m0_stall} !== 3'b001) begin n_bad++; $display("FAIL dl_release got err/cyc/st0=%b want 001", {m0_err, s_cyc, m0_stall}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_m(1, 1); m1_dat_w = 32'hE1; m0_dat_w = 32'hE0;
    @(negedge clk);
    #1;
    n_cmp++; if (s_cyc !== 1'b1 || s_dat_w !== 32'hE1) begin n_bad++; $display("FAIL rm_granted got cyc=%b dat=%h want 1 E1", s_cyc, s_dat_w); end
    #1;
    rst = 1'b1;
    set_m(0, 1);
    #1;
    n_cmp++; if ({s_cyc, m1_stall} !== 2'b01) begin n_bad++; $display("FAIL rm_async got cyc/st1=%b want 01", {s_cyc, m1_stall}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (s_cyc !== 1'b0) begin n_bad++; $display("FAIL rm_idle got cyc=%b want 0", s_cyc); end
    @(negedge clk);
    #1;
    n_cmp++; if (s_dat_w !== 32'hE0 || {m0_stall, m1_stall} !== 2'b01) begin
      n_bad++; $display("FAIL rm_tie got dat=%h st0/st1=%b want E0 01", s_dat_w, {m0_stall, m1_stall});
    end
    @(negedge clk);
    clear_in();
    @(negedge clk);
  endtask

  // Reference: who owns the slave, who is being told err, who won last,
  // and how many granted cycles in a row went without an ack.
  task automatic test_random();
    int mo, me, ml, miss, cur, oth;
    logic [34:0] exp_s, exp_0, exp_1;
    do_reset();
    mo = -1; me = -1; ml = 1; miss = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 4) == 0) m1_cyc = ~m1_cyc;
      m0_stb = $urandom_range(0, 1); m0_we = $urandom_range(0, 1); m0_dat_w = $urandom;
      m1_stb = $urandom_range(0, 1); m1_we = $urandom_range(0, 1); m1_dat_w = $urandom;
      s_ack = ($urandom_range(0, 3) == 0); s_stall = $urandom_range(0, 1); s_dat_r = $urandom;
      #1;
      exp_s = (mo == 0) ? {m0_cyc, m0_stb, m0_we, m0_dat_w} :
              (mo == 1) ? {m1_cyc, m1_stb, m1_we, m1_dat_w} : 35'h0;
      exp_0 = (mo == 0) ? {s_ack, s_stall, 1'b0, s_dat_r} : {1'b0, 1'b1, me == 0, 32'h0};
      exp_1 = (mo == 1) ? {s_ack, s_stall, 1'b0, s_dat_r} : {1'b0, 1'b1, me == 1, 32'h0};
      n_cmp++; if ({s_cyc, s_stb, s_we, s_dat_w} !== exp_s) begin n_bad++; $display("FAIL rnd_slave c%0d got %h want %h", c, {s_cyc, s_stb, s_we, s_dat_w}, exp_s); end
      n_cmp++; if ({m0_ack, m0_stall, m0_err, m0_dat_r} !== exp_0) begin n_bad++; $display("FAIL rnd_m0 c%0d got %h want %h", c, {m0_ack, m0_stall, m0_err, m0_dat_r}, exp_0); end
      n_cmp++; if ({m1_ack, m1_stall, m1_err, m1_dat_r} !== exp_1) begin n_bad++; $display("FAIL rnd_m1 c%0d got %h want %h", c, {m1_ack, m1_stall, m1_err, m1_dat_r}, exp_1); end
      if (me >= 0) begin
        me = -1;
      end else if (mo < 0) begin
        if (m0_cyc || m1_cyc) begin
          mo = (m0_cyc && m1_cyc) ? 1 - ml : (m0_cyc ? 0 : 1);
          ml = mo; miss = 0;
        end
      end else begin
        cur = (mo == 1) ? int'(m1_cyc) : int'(m0_cyc);
        oth = (mo == 1) ? int'(m0_cyc) : int'(m1_cyc);
        if (cur == 0) begin
          if (oth != 0) begin mo = 1 - mo; ml = mo; miss = 0; end
          else mo = -1;
        end else if (s_ack) begin
          miss = 0;
        end else begin
          miss++;
          if (miss == TMO) begin me = mo; mo = -1; miss = 0; end
        end
      end
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_write();
    test_round_robin();
    test_pipelined_read();
    test_timeout();
    test_ack_deadline();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
